delay_time_controller: RTL and testbench

Sequencer that drives the `delay_samples` input of the variable delay buffer in the echo/delay effect. It takes new delay requests from the control path and moves the buffer's read offset without audible clicks. Small changes are slewed one sample at a time. Large changes use a wet-gain fade-out, a pointer jump, and a fade-in. It sits between the control register/MIDI mapping logic and the delay buffer plus wet/dry mixer, and is advanced by the audio `sample_valid` strobe.

---
 rtl/delay_ctrl_pkg.sv | 21 ++
 rtl/delay_time_controller.sv | 118 +++++++++++
 tb/tb_delay_time_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : delay_ctrl_pkg
//  Brief    : Shared state type and gain constants for the delay controller.
//  Revision : 1.0
// ============================================================================
package delay_ctrl_pkg;

  localparam int GAIN_WIDTH = 16;
  localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = 16'h8000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SLEW     = 3'd1,
    FADE_OUT = 3'd2,
    JUMP     = 3'd3,
    FADE_IN  = 3'd4
  } delay_state_t;

endpackage
`default_nettype wire

// File: rtl/delay_time_controller.sv
`default_nettype none
// ============================================================================
//  Module   : delay_time_controller
//  Brief    : Moves the delay-buffer read offset click-free: short moves are
//             slewed, long moves use fade-out / pointer jump / fade-in.
//  Revision : 1.0
// ============================================================================
module delay_time_controller
  import delay_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int RESET_DELAY = 4800,
  parameter int MIN_DELAY   = 2,
  parameter int SLEW_DIV    = 4,
  parameter int JUMP_THRESH = 64,
  parameter int FADE_LOG2   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic                  cfg_valid,
  input  logic [ADDR_WIDTH-1:0] cfg_delay,
  output logic                  cfg_ready,
  output logic [ADDR_WIDTH-1:0] delay_samples,
  output logic [GAIN_WIDTH-1:0] wet_gain,
  output logic                  busy
);

  localparam int c_FADE_W = FADE_LOG2 + 1;
  localparam int c_TICK_W = $clog2(SLEW_DIV + 1);
  localparam logic [c_FADE_W-1:0]   c_FADE_FULL = c_FADE_W'(1 << FADE_LOG2);
  localparam logic [c_FADE_W-1:0]   c_FADE_ONE  = c_FADE_W'(1);
  localparam logic [c_TICK_W-1:0]   c_TICK_LAST = c_TICK_W'(SLEW_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] c_MIN       = ADDR_WIDTH'(MIN_DELAY);

  delay_state_t            r_state;
  delay_state_t            w_next_state;
  logic [ADDR_WIDTH-1:0]   r_target;
  logic [ADDR_WIDTH-1:0]   r_delay;
  logic [c_TICK_W-1:0]     r_tick;
  logic [c_FADE_W-1:0]     r_fade;

  logic signed [ADDR_WIDTH:0] w_diff;
  logic [ADDR_WIDTH:0]        w_abs;
  logic                       w_zero;
  logic                       w_small;
  logic                       w_accept;
  logic [ADDR_WIDTH-1:0]      w_cfg_clamped;

  // Diff is widened by one bit so it never wraps across the address range.
  assign w_diff        = $signed({1'b0, r_target}) - $signed({1'b0, r_delay});
  assign w_abs         = w_diff[ADDR_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_zero        = (w_diff == '0);
  assign w_small       = (w_abs <= (ADDR_WIDTH+1)'(JUMP_THRESH));
  assign w_accept      = cfg_valid && cfg_ready;
  assign w_cfg_clamped = (cfg_delay < c_MIN) ? c_MIN : cfg_delay;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE, SLEW: begin
        if (w_zero)       w_next_state = IDLE;
        else if (w_small) w_next_state = SLEW;
        else              w_next_state = FADE_OUT;
      end
      FADE_OUT: if (sample_valid && r_fade == c_FADE_ONE) w_next_state = JUMP;
      JUMP:     w_next_state = FADE_IN;
      FADE_IN:  if (sample_valid && r_fade == c_FADE_FULL - c_FADE_ONE) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_target <= ADDR_WIDTH'(RESET_DELAY);
      r_delay  <= ADDR_WIDTH'(RESET_DELAY);
      r_tick   <= '0;
      r_fade   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) r_target <= w_cfg_clamped;
      unique case (r_state)
        IDLE: if (w_next_state == FADE_OUT) r_fade <= c_FADE_FULL;
        SLEW: begin
          // The tick count survives retargets; it only restarts after a step or on leaving SLEW.
          if (w_next_state != SLEW) begin
            r_tick <= '0;
          end else if (sample_valid) begin
            if (r_tick == c_TICK_LAST) begin
              r_tick  <= '0;
              r_delay <= w_diff[ADDR_WIDTH] ? r_delay - ADDR_WIDTH'(1) : r_delay + ADDR_WIDTH'(1);
            end else begin
              r_tick <= r_tick + c_TICK_W'(1);
            end
          end
          if (w_next_state == FADE_OUT) r_fade <= c_FADE_FULL;
        end
        FADE_OUT: if (sample_valid) r_fade <= r_fade - c_FADE_ONE;
        JUMP:     r_delay <= r_target;
        FADE_IN:  if (sample_valid) r_fade <= r_fade + c_FADE_ONE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    cfg_ready     = (r_state == IDLE) || (r_state == SLEW);
    busy          = (r_state != IDLE);
    delay_samples = r_delay;
    if (r_state == FADE_OUT || r_state == JUMP || r_state == FADE_IN)
      wet_gain = GAIN_WIDTH'(r_fade) << (15 - FADE_LOG2);
    else
      wet_gain = GAIN_UNITY;
  end

endmodule
`default_nettype wire

// File: tb/tb_delay_time_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delay_time_controller
//  Brief    : Randomised and directed bench for delay_time_controller against
//             a behavioural model of the slew / fade-jump rules.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_delay_time_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic        cfg_ready;
  logic [15:0] delay_samples;
  logic [15:0] wet_gain;
  logic        busy;

  delay_time_controller dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .cfg_valid     (cfg_valid),
    .cfg_delay     (cfg_delay),
    .cfg_ready     (cfg_ready),
    .delay_samples (delay_samples),
    .wet_gain      (wet_gain),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modes are plain integers, arithmetic on ints.
  localparam int M_IDLE = 0, M_SLEW = 1, M_FOUT = 2, M_JUMP = 3, M_FIN = 4;
  int m_delay, m_target, m_mode, m_tick, m_fade;
  bit m_on = 0;

  always @(posedge clk) begin : model
    int diff, mag;
    bit acc;
    if (reset) begin
      m_delay = 4800; m_target = 4800; m_mode = M_IDLE; m_tick = 0; m_fade = 0; m_on = 1;
    end else if (m_on) begin
      diff = m_target - m_delay;
      mag  = (diff < 0) ? -diff : diff;
      acc  = cfg_valid && (m_mode == M_IDLE || m_mode == M_SLEW);
      case (m_mode)
        M_IDLE, M_SLEW: begin
          if (diff == 0) begin
            m_mode = M_IDLE; m_tick = 0;
          end else if (mag <= 64) begin
            if (m_mode == M_SLEW && sample_valid) begin
              m_tick++;
              if (m_tick == 4) begin
                m_tick = 0;
                m_delay += (diff > 0) ? 1 : -1;
              end
            end
            m_mode = M_SLEW;
          end else begin
            m_mode = M_FOUT; m_fade = 256; m_tick = 0;
          end
        end
        M_FOUT: if (sample_valid) begin
          m_fade--;
          if (m_fade == 0) m_mode = M_JUMP;
        end
        M_JUMP: begin m_delay = m_target; m_mode = M_FIN; end
        default: if (sample_valid) begin
          m_fade++;
          if (m_fade == 256) m_mode = M_IDLE;
        end
      endcase
      if (acc) m_target = (int'(cfg_delay) < 2) ? 2 : int'(cfg_delay);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("delay_samples", int'(delay_samples), m_delay);
      check("wet_gain", int'(wet_gain), (m_mode >= M_FOUT) ? m_fade * 128 : 32768);
      check("cfg_ready", int'(cfg_ready), (m_mode <= M_SLEW) ? 1 : 0);
      check("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
    end
  end

  // Sample strobe generator: 0 = every 4th cycle, 1 = every 2nd, 2 = random.
  int sv_mode = 0;
  int sv_phase = 0;
  always @(posedge clk) begin
    #1;
    case (sv_mode)
      0:       sample_valid = (sv_phase % 4 == 3);
      1:       sample_valid = (sv_phase % 2 == 1);
      default: sample_valid = ($urandom_range(2) == 0);
    endcase
    sv_phase++;
  end

  int busy_ticks = 0;
  always @(posedge clk) if (sample_valid && busy) busy_ticks++;

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic request(input int val);
    int b = 0;
    cfg_valid = 1'b1;
    cfg_delay = 16'(val);
    while (!cfg_ready && b < 3000) begin cyc(); b++; end
    if (!cfg_ready) check("request_timeout", int'(cfg_ready), 1);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_delay(input int val);
    int b = 0;
    while (int'(delay_samples) != val && b < 5000) begin cyc(); b++; end
    if (int'(delay_samples) != val) check("wait_delay_timeout", int'(delay_samples), val);
  endtask

  task automatic wait_idle();
    int b = 0;
    cyc();
    while (busy && b < 5000) begin cyc(); b++; end
    if (busy) check("wait_idle_timeout", int'(busy), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, mx, val;
    // Reset values
    cyc(2);
    check("reset_delay", int'(delay_samples), 4800);
    check("reset_gain", int'(wet_gain), 32768);
    check("reset_ready", int'(cfg_ready), 1);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    cyc();

    // Short slew
    sv_mode = 0;
    busy_ticks = 0;
    request(4810);
    check("busy_after_1", int'(busy), 0);
    cyc();
    check("busy_after_2", int'(busy), 1);
    wait_delay(4810);
    check("slew_ticks", busy_ticks, 40);
    wait_idle();
    check("slew_end_delay", int'(delay_samples), 4810);
    check("slew_end_gain", int'(wet_gain), 32768);

    // Long jump
    sv_mode = 1;
    request(24000);
    bad = 0;
    while (int'(delay_samples) != 24000 && bad < 100000) begin
      cyc();
      if (busy && cfg_ready) bad += 1;
      if (int'(delay_samples) != 4810 && int'(delay_samples) != 24000) bad += 100000;
    end
    check("jump_first_gain", int'(wet_gain), 0);
    check("jump_ready_or_ptr", bad, 0);
    wait_idle();
    check("jump_end_delay", int'(delay_samples), 24000);
    check("jump_end_gain", int'(wet_gain), 32768);

    // Clamp and no-op
    request(0);
    wait_idle();
    check("clamp_delay", int'(delay_samples), 2);
    request(2);
    mx = 0;
    repeat (10) begin cyc(); if (busy) mx = 1; end
    check("noop_busy", mx, 0);

    // Retarget mid-slew
    reset = 1'b1; cyc(); reset = 1'b0;
    sv_mode = 0;
    request(4830);
    wait_delay(4802);
    busy_ticks = 0;
    request(4790);
    wait_delay(4790);
    check("retarget_ticks", busy_ticks, 48);
    wait_idle();

    // Reset mid-fade
    sv_mode = 1;
    request(9000);
    wait_delay(9000);
    bad = 0;
    while (wet_gain != 16'h2000 && bad < 2000) begin cyc(); bad++; end
    check("fade_in_gain", int'(wet_gain), 16'h2000);
    reset = 1'b1;
    cyc();
    check("rst_mid_delay", int'(delay_samples), 4800);
    check("rst_mid_gain", int'(wet_gain), 32768);
    check("rst_mid_ready", int'(cfg_ready), 1);
    check("rst_mid_busy", int'(busy), 0);
    reset = 1'b0;
    cyc();

    // Randomised requests
    for (int i = 0; i < 30; i++) begin
      sv_mode = 1 + int'($urandom_range(1));
      case ($urandom_range(3))
        0, 1: begin
          val = m_delay + int'($urandom_range(200)) - 100;
          if (val < 0) val = 0;
          if (val > 65535) val = 65535;
        end
        2:       val = int'($urandom_range(65535));
        default: val = int'($urandom_range(5));
      endcase
      request(val);
      if ($urandom_range(9) == 0) begin
        cyc(int'($urandom_range(20)));
        reset = 1'b1; cyc(); reset = 1'b0;
      end else if ($urandom_range(1) == 0) begin
        wait_idle();
      end else begin
        cyc(int'($urandom_range(300)));
      end
    end
    wait_idle();
    cyc(5);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
